// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types.
package cpu_pkg;

  localparam int unsigned PC_WIDTH     = 32;
  localparam int unsigned PC_INCREMENT = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_adder_const_adder.sv
// Width-parameterized adder of a compile-time constant, with carry-out.
module const_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INCREMENT = 4
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum_full;

  // One extra bit so the carry-out falls out of a single carry-propagate add.
  assign sum_full = {1'b0, a_i} + (WIDTH+1)'(INCREMENT);
  assign sum_o    = sum_full[WIDTH-1:0];
  assign carry_o  = sum_full[WIDTH];

endmodule

// File: rtl/pc_adder.sv
// Fetch-stage next-sequential-PC generator with a sticky wrap-around debug flag.
module pc_adder
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = cpu_pkg::PC_WIDTH,
  parameter int unsigned PC_INCREMENT = cpu_pkg::PC_INCREMENT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcAddr,
  output logic                wrap,
  output logic                wrap_seen
);

  if (PC_WIDTH < 1) begin : g_bad_width
    $error("pc_adder: PC_WIDTH must be at least 1");
  end
  if (PC_INCREMENT == 0 || (PC_INCREMENT >> PC_WIDTH) != 0) begin : g_bad_incr
    $error("pc_adder: PC_INCREMENT must lie in (0, 2**PC_WIDTH)");
  end

  const_adder #(
    .WIDTH    (PC_WIDTH),
    .INCREMENT(PC_INCREMENT)
  ) u_add (
    .a_i    (pc),
    .sum_o  (pcAddr),
    .carry_o(wrap)
  );

  logic wrap_seen_q, wrap_seen_d;

  always_comb begin
    wrap_seen_d = wrap_seen_q;
    if (rst) begin
      wrap_seen_d = 1'b0;
    end else if (wrap) begin
      wrap_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    wrap_seen_q <= wrap_seen_d;
  end

  assign wrap_seen = wrap_seen_q;

  always_comb begin
    if (!$isunknown(pc)) begin
      assert (pcAddr == pc + PC_WIDTH'(PC_INCREMENT))
        else $error("pc_adder: pcAddr %h does not equal pc %h + increment", pcAddr, pc);
    end
  end

endmodule

// File: tb/tb_pc_adder.sv
// Directed and swept checks of pc_adder's sum, carry and sticky wrap flag.
module tb_pc_adder;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pcAddr;
  logic        wrap;
  logic        wrap_seen;

  int n_cmp;
  int n_bad;

  pc_adder #(
    .PC_WIDTH    (32),
    .PC_INCREMENT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .pcAddr   (pcAddr),
    .wrap     (wrap),
    .wrap_seen(wrap_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic        exp_wrap;

    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    pc    = 32'h0000_0000;

    #10;
    check("pcAddr_zero", pcAddr, 32'h0000_0004);
    check("wrap_zero", {31'd0, wrap}, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    pc  = 32'h0000_0012;
    #1;
    check("pcAddr_in_reset", pcAddr, 32'h0000_0016);
    check("wrap_in_reset", {31'd0, wrap}, 32'd0);
    @(negedge clk);
    check("wrap_seen_after_reset", {31'd0, wrap_seen}, 32'd0);

    rst = 1'b0;
    pc  = 32'h0001_0000;
    #1;
    check("pcAddr_10000", pcAddr, 32'h0001_0004);
    @(negedge clk);
    check("wrap_seen_idle_a", {31'd0, wrap_seen}, 32'd0);
    pc = 32'h0000_0008;
    #1;
    check("pcAddr_8", pcAddr, 32'h0000_000C);
    @(negedge clk);
    check("wrap_seen_idle_b", {31'd0, wrap_seen}, 32'd0);

    pc = 32'hFFFF_FFFC;
    #1;
    check("pcAddr_top", pcAddr, 32'h0000_0000);
    check("wrap_top", {31'd0, wrap}, 32'd1);
    check("wrap_seen_latency", {31'd0, wrap_seen}, 32'd0);
    @(negedge clk);
    check("wrap_seen_set", {31'd0, wrap_seen}, 32'd1);
    pc = 32'h0000_0100;
    #1;
    check("pcAddr_100", pcAddr, 32'h0000_0104);
    check("wrap_100", {31'd0, wrap}, 32'd0);
    @(negedge clk);
    check("wrap_seen_sticky", {31'd0, wrap_seen}, 32'd1);

    rst = 1'b1;
    pc  = 32'hFFFF_FFFE;
    #1;
    check("pcAddr_fffe_rst", pcAddr, 32'h0000_0002);
    check("wrap_fffe_rst", {31'd0, wrap}, 32'd1);
    @(negedge clk);
    check("wrap_seen_rst_priority", {31'd0, wrap_seen}, 32'd0);
    @(negedge clk);
    check("wrap_seen_rst_held", {31'd0, wrap_seen}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("wrap_seen_reset_release", {31'd0, wrap_seen}, 32'd1);

    rst = 1'b1;
    pc  = 32'h0000_0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rpc = $urandom;
      if (i % 50 == 0) rpc = 32'hFFFF_FFF8 + 32'(i % 8);
      pc = rpc;
      #1;
      exp_addr = rpc + 32'd4;
      exp_wrap = (rpc >= 32'hFFFF_FFFC);
      check("sweep_pcAddr", pcAddr, exp_addr);
      check("sweep_wrap", {31'd0, wrap}, {31'd0, exp_wrap});
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
